// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin scheduler sharing one shift-and-add multiplier
// Grants one requester at a time, runs one partial-product row per cycle, returns product and ID.
module mult_share_sched #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_product,
  output logic                busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             busy_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic [2*W-1:0]   pp;

  // Cyclic search starting just after the previous winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign pp = {{W{1'b0}}, a_q & {W{b_q[cnt_q]}}} << cnt_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = rst_n;
          a_d     = req_a[gnt_idx*W +: W];
          b_d     = req_b[gnt_idx*W +: W];
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + pp;
        // cnt holds at W-1 on the final row instead of wrapping.
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_product = acc_q;
  assign rsp_id      = id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - directed self-checking bench for mult_share_sched
// Linear directed steps with hand-computed products, grants and latencies.
module tb_mult_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*W-1:0]    rsp_product;
  logic              busy;

  int vectors;
  int miscompares;

  mult_share_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_product(rsp_product),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 8);
  endtask

  // One full operation: grant check, handshake, latency, response, consume.
  task automatic do_op(input string tag, input logic [3:0] exp_ready, input int exp_id,
                       input logic [15:0] exp_prod, input bit drop);
    #1;
    chk({tag, "_ready"}, req_ready, exp_ready);
    tick();
    if (drop) req_valid[exp_id] = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_rsp(tag);
    chk({tag, "_id"}, rsp_id, exp_id);
    chk({tag, "_prod"}, rsp_product, exp_prod);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_consumed"}, rsp_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = '1;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b0;

    // Reset state, with requests pending to prove req_ready is forced low.
    tick();
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_prod", rsp_product, 16'h0000);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single op from requester 2: 0xFF * 0xFF.
    set_op(2, 8'hFF, 8'hFF);
    do_op("single", 4'b0100, 2, 16'hFE01, 1'b1);
    chk("single_idle_busy", busy, 0);

    // All four requesters together from reset.
    do_reset();
    set_op(0, 8'h03, 8'h05);
    set_op(1, 8'h07, 8'h09);
    set_op(2, 8'h80, 8'h02);
    set_op(3, 8'h10, 8'h10);
    do_op("all0", 4'b0001, 0, 16'h000F, 1'b1);
    do_op("all1", 4'b0010, 1, 16'h003F, 1'b1);
    do_op("all2", 4'b0100, 2, 16'h0100, 1'b1);
    do_op("all3", 4'b1000, 3, 16'h0100, 1'b1);

    // Backpressure on requester 1's result while requester 0 waits.
    set_op(1, 8'h0F, 8'h11);
    #1;
    chk("bp_ready", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    set_op(0, 8'h00, 8'hAB);
    wait_rsp("bp");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_prod", rsp_product, 16'h00FF);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready_low", req_ready, 4'b0000);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release", rsp_valid, 0);
    chk("bp_release_busy", busy, 0);

    // Zero and one operands.
    do_op("zero", 4'b0001, 0, 16'h0000, 1'b1);
    set_op(2, 8'h01, 8'hAB);
    do_op("one_a", 4'b0100, 2, 16'h00AB, 1'b1);
    set_op(3, 8'hAB, 8'h01);
    do_op("one_b", 4'b1000, 3, 16'h00AB, 1'b1);

    // Fairness: 0 and 3 held valid, last grant was 3.
    set_op(0, 8'h02, 8'h03);
    set_op(3, 8'h05, 8'h07);
    for (int r = 0; r < 3; r++) begin
      do_op("fair0", 4'b0001, 0, 16'h0006, 1'b0);
      do_op("fair3", 4'b1000, 3, 16'h0023, 1'b0);
    end
    req_valid = '0;

    // Reset on the 4th RUN cycle discards the in-flight op.
    set_op(1, 8'h12, 8'h34);
    #1;
    chk("mid_ready", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_valid", rsp_valid, 0);
    chk("mid_prod", rsp_product, 16'h0000);
    chk("mid_id", rsp_id, 0);
    tick();
    tick();
    rst_n = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (rsp_valid) stale++;
      end
      chk("mid_no_stale", stale, 0);
    end
    set_op(1, 8'h12, 8'h34);
    do_op("reissue", 4'b0010, 1, 16'h03A8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
